// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub: operands and opcode in,
// busy/done status plus result and flags out.
interface serial_addsub_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, DIGIT bits per cycle: WIDTH/DIGIT cycles from accept to done.
// No backpressure: start is taken only in IDLE/DONE and ignored while busy.
module serial_addsub #(
  parameter int  WIDTH = 64,
  parameter int  DIGIT = 4,
  parameter real DELAY = 0.05
) (
  input logic            clk,
  input logic            reset_n,
  serial_addsub_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // DELAY only models gate timing in gate-level views; the RTL just sanity-checks it.
  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0) || (DELAY < 0.0)) begin : g_bad_params
      $error("serial_addsub: WIDTH must be a positive multiple of DIGIT and DELAY >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] acc_next;

  // Ripple chain over one digit: c[i] is the carry into bit i of the digit.
  always_comb begin
    p    = '0;
    g    = '0;
    dsum = '0;
    c    = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      p[i]     = op_a[i] ^ op_b[i];
      g[i]     = op_a[i] & op_b[i];
      dsum[i]  = p[i] ^ c[i];
      c[i+1]   = g[i] | (p[i] & c[i]);
    end
    acc_next = WIDTH'({dsum, acc} >> DIGIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      result_q <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= bus.b ^ {WIDTH{bus.sub}};
            carry  <= bus.sub;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          acc   <= acc_next;
          carry <= c[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            result_q <= acc_next;
            cout_q   <= c[DIGIT];
            ovf_q    <= c[DIGIT] ^ c[DIGIT-1];
            zero_q   <= (acc_next == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule
